dma_window_engine: RTL and testbench
====================================

Name: dma_window_engine

Overview:
- Memory-side responder for the CNN controller's DMA request/finish handshake.
- Accepts one request at a time: read a KxK window, write one word, load a KxK filter, or load a bias vector.
- Sequences single-word RAM accesses to carry out the request.
- Sits between the CNN controller (requests), the RAM (1-cycle read latency) and the filter buffer (streamed writes); the controller holds start until it sees finish.

Parameters:
K, 5, window/filter side length; K*K words per window or filter.
DW, 16, data word width.
AW, 16, memory address width.
MAXB, 120, maximum bias count per load.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset.
start  in  1  request, level; held high by the controller until finish is seen.
op  in  2  0 = read window, 1 = write word, 2 = load filter, 3 = load bias.
start_address  in  AW  base address of the request.
offset  in  AW  row stride for read window (words).
filter_number  in  8  op 2: filter index; op 3: bias count.
cnn_in_data  in  DW  write data for op 1.
finish  out  1  request complete.
window_out  out  K*K*DW  element (r,c) at bits [(r*K+c)*DW +: DW].
mem_en  out  1  RAM access enable.
mem_write  out  1  1 = write, 0 = read.
mem_addr  out  AW  RAM word address.
mem_wdata  out  DW  RAM write data.
mem_rdata  in  DW  RAM read data, valid the cycle after the address is sampled.
fb_write  out  1  one-cycle filter-buffer write strobe.
fb_bias_sel  out  1  0 = filter slot, 1 = bias slot.
fb_index  out  7  element index: 0..K*K-1 for a filter, 0..MAXB-1 for a bias.
fb_data  out  DW  filter-buffer write data.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; finish, mem_en, mem_write, fb_write, fb_bias_sel = 0; mem_addr, mem_wdata, fb_index, fb_data = 0; window_out all zero. All counters cleared. Any in-flight transfer is abandoned and no further RAM access is issued.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: on an edge with start=1, latch op, start_address, offset, filter_number and cnn_in_data (edge E0). Go to ISSUE; for op 3 with count 0, go directly to DONE.
- Read address sequence, element k = 0..N-1, issued in the cycle after E_k:
  - op 0: start_address + (k/K)*offset + (k%K); N = K*K.
  - op 2: start_address + filter_number*K*K + k; N = K*K.
  - op 3: start_address + k; N = min(filter_number, MAXB).
  - All address arithmetic is truncated modulo 2^AW; wrap-around is legal and is not flagged.
- Pipelining: issue is back-to-back, mem_en=1 and mem_write=0 in every ISSUE cycle. Data for element k is captured at edge E_{k+2}. DRAIN lasts one cycle and captures the last element.
- Capture targets:
  - op 0: write window_out element k.
  - op 2: fb_write=1 for exactly one cycle after E_{k+2}, with fb_index=k, fb_bias_sel=0, fb_data=captured word.
  - op 3: same as op 2 but with fb_bias_sel=1.
  - window_out changes only during op 0.
- Write word (op 1): in the cycle after E0, mem_en=1, mem_write=1, mem_addr=start_address, mem_wdata=latched cnn_in_data. The state reaches DONE at E1 and finish=1 after E1.
- Latency from start sampled to finish high: op 0 / op 2 = K*K+1 edges (26 at K=5); op 3 = N+1 edges; op 1 = 1 edge; op 3 with count 0 = 1 edge.
- DONE: finish=1 and mem_en=0. finish stays high while start=1, then drops on the first edge with start=0 and the state returns to IDLE.
  - A new request needs start low for at least one edge; a start held high never retriggers.
  - If start is already low when DONE is entered, finish is high for exactly one cycle.
- Input changes during a transfer: start dropping mid-transfer is ignored and the transfer completes. Changes to op, address, offset, count or data after E0 are ignored.
- mem_en=0 in IDLE and DONE; mem_write=1 only during the op 1 write cycle.

Test Plan:
- Async reset (reset=0) asserted mid-transfer at k=10 of op 0 -> all outputs 0 immediately, no further mem_en, IDLE after reset=1.
- op 0, start_address=100, offset=32, RAM[a]=a -> mem_addr sequence 100..104, 132..136, ..., 228..232; finish 26 edges after E0; window_out(2,3)=167.
- op 1, start_address=0xFFFF, cnn_in_data=0x1234 -> one write cycle to 0xFFFF with data 0x1234; finish after E1; start held 5 cycles -> finish high 5 cycles, then low one edge after start drops.
- op 2, filter_number=3, start_address=0, RAM[a]=a^0x5A5A -> reads 75..99; 25 fb_write pulses, fb_index 0..24, fb_bias_sel=0; window_out unchanged.
- op 3, count 6 from 50550 -> six reads, six fb_write pulses with fb_bias_sel=1 and indices 0..5; op 3 with count 0 -> no mem_en, finish after E1.
- op 0, start_address=0xFFF0, offset=8 -> addresses wrap modulo 2^16 (row 2 starts at 0x0000); start dropped at k=3 -> finish pulses exactly one cycle after E26.

Source files
------------

// File: rtl/dma_window_engine_if.sv
// Bundle of the controller handshake, RAM port and filter-buffer port of the DMA window engine.
// The engine connects through the slave modport; the master modport is the surrounding system.
interface dma_window_engine_if #(
    parameter int K  = 5,
    parameter int DW = 16,
    parameter int AW = 16
);
    logic                  start;
    logic [1:0]            op;
    logic [AW-1:0]         start_address;
    logic [AW-1:0]         offset;
    logic [7:0]            filter_number;
    logic [DW-1:0]         cnn_in_data;
    logic                  finish;
    logic [K*K*DW-1:0]     window_out;
    logic                  mem_en;
    logic                  mem_write;
    logic [AW-1:0]         mem_addr;
    logic [DW-1:0]         mem_wdata;
    logic [DW-1:0]         mem_rdata;
    logic                  fb_write;
    logic                  fb_bias_sel;
    logic [6:0]            fb_index;
    logic [DW-1:0]         fb_data;

    modport master (
        output start, op, start_address, offset, filter_number, cnn_in_data, mem_rdata,
        input  finish, window_out, mem_en, mem_write, mem_addr, mem_wdata,
               fb_write, fb_bias_sel, fb_index, fb_data
    );

    modport slave (
        input  start, op, start_address, offset, filter_number, cnn_in_data, mem_rdata,
        output finish, window_out, mem_en, mem_write, mem_addr, mem_wdata,
               fb_write, fb_bias_sel, fb_index, fb_data
    );
endinterface

// File: rtl/dma_window_engine.sv
// DMA responder: turns one controller request into a back-to-back stream of single-word
// RAM accesses, feeding either the KxK window register or the filter/bias buffer.
module dma_window_engine #(
    parameter int K    = 5,
    parameter int DW   = 16,
    parameter int AW   = 16,
    parameter int MAXB = 120
) (
    input  logic                  clk,
    input  logic                  reset,
    dma_window_engine_if.slave    bus
);
    localparam int NW = K * K;
    localparam int IW = 7;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t             r_state;
    logic [1:0]         r_op;
    logic [AW-1:0]      r_offset;
    logic [AW-1:0]      r_row_base;
    logic [IW-1:0]      r_col;
    logic [IW-1:0]      r_k;
    logic [IW-1:0]      r_last;
    logic               r_smp_v;
    logic [IW-1:0]      r_smp_idx;
    logic               r_finish;
    logic               r_mem_en;
    logic               r_mem_write;
    logic [AW-1:0]      r_mem_addr;
    logic [DW-1:0]      r_mem_wdata;
    logic [NW*DW-1:0]   r_window;
    logic               r_fb_write;
    logic               r_fb_bias_sel;
    logic [IW-1:0]      r_fb_index;
    logic [DW-1:0]      r_fb_data;

    logic [AW-1:0]      w_base;
    logic [IW-1:0]      w_cnt;
    logic               w_empty;

    // Request decode from the live inputs, only consumed on the accepting edge.
    always_comb begin
        w_base  = bus.start_address +
                  ((bus.op == 2'd2) ? (AW'(bus.filter_number) * AW'(NW)) : {AW{1'b0}});
        w_cnt   = (bus.filter_number > 8'(MAXB)) ? IW'(MAXB) : bus.filter_number[IW-1:0];
        w_empty = (bus.op == 2'd3) && (bus.filter_number == 8'd0);
    end

    // Request FSM and RAM address sequencer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_op        <= 2'd0;
            r_offset    <= {AW{1'b0}};
            r_row_base  <= {AW{1'b0}};
            r_col       <= {IW{1'b0}};
            r_k         <= {IW{1'b0}};
            r_last      <= {IW{1'b0}};
            r_smp_v     <= 1'b0;
            r_smp_idx   <= {IW{1'b0}};
            r_finish    <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= {AW{1'b0}};
            r_mem_wdata <= {DW{1'b0}};
        end else begin
            // The RAM samples the presented read address on this edge; data follows one cycle later.
            r_smp_v   <= r_mem_en & ~r_mem_write;
            r_smp_idx <= r_k;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_op        <= bus.op;
                        r_offset    <= bus.offset;
                        r_row_base  <= w_base;
                        r_col       <= {IW{1'b0}};
                        r_k         <= {IW{1'b0}};
                        r_last      <= (bus.op == 2'd3) ? (w_cnt - IW'(1)) : IW'(NW - 1);
                        r_mem_addr  <= w_base;
                        r_mem_wdata <= bus.cnn_in_data;
                        if (w_empty) begin
                            r_state <= DONE;
                        end else begin
                            r_state     <= ISSUE;
                            r_mem_en    <= 1'b1;
                            r_mem_write <= (bus.op == 2'd1);
                        end
                    end
                end
                ISSUE: begin
                    if (r_op == 2'd1) begin
                        r_state     <= DONE;
                        r_mem_en    <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_finish    <= 1'b1;
                    end else if (r_k == r_last) begin
                        r_state  <= DRAIN;
                        r_mem_en <= 1'b0;
                    end else begin
                        r_k <= r_k + IW'(1);
                        // Window reads jump to the next row after K columns; other ops stay linear.
                        if ((r_op == 2'd0) && (r_col == IW'(K - 1))) begin
                            r_col      <= {IW{1'b0}};
                            r_row_base <= r_row_base + r_offset;
                            r_mem_addr <= r_row_base + r_offset;
                        end else begin
                            r_col      <= r_col + IW'(1);
                            r_mem_addr <= r_mem_addr + AW'(1);
                        end
                    end
                end
                DRAIN: begin
                    r_state  <= DONE;
                    r_finish <= 1'b1;
                end
                DONE: begin
                    if (bus.start) begin
                        r_finish <= 1'b1;
                    end else begin
                        r_finish <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_finish    <= 1'b0;
                    r_mem_en    <= 1'b0;
                    r_mem_write <= 1'b0;
                end
            endcase
        end
    end

    // Read-data capture into the window register or the filter/bias buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_window      <= {(NW*DW){1'b0}};
            r_fb_write    <= 1'b0;
            r_fb_bias_sel <= 1'b0;
            r_fb_index    <= {IW{1'b0}};
            r_fb_data     <= {DW{1'b0}};
        end else if (r_smp_v) begin
            if (r_op == 2'd0) begin
                r_fb_write <= 1'b0;
                for (int i = 0; i < NW; i++) begin
                    if (r_smp_idx == IW'(i)) begin
                        r_window[i*DW +: DW] <= bus.mem_rdata;
                    end
                end
            end else begin
                r_fb_write    <= 1'b1;
                r_fb_bias_sel <= (r_op == 2'd3);
                r_fb_index    <= r_smp_idx;
                r_fb_data     <= bus.mem_rdata;
            end
        end else begin
            r_fb_write <= 1'b0;
        end
    end

    assign bus.finish      = r_finish;
    assign bus.window_out  = r_window;
    assign bus.mem_en      = r_mem_en;
    assign bus.mem_write   = r_mem_write;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_wdata   = r_mem_wdata;
    assign bus.fb_write    = r_fb_write;
    assign bus.fb_bias_sel = r_fb_bias_sel;
    assign bus.fb_index    = r_fb_index;
    assign bus.fb_data     = r_fb_data;
endmodule

// File: tb/tb_dma_window_engine.sv
// Self-checking bench for dma_window_engine: request table plus reset corner case,
// with address, write and filter-buffer scoreboards fed from a reference model.
module tb_dma_window_engine;
    localparam int K    = 5;
    localparam int DW   = 16;
    localparam int AW   = 16;
    localparam int MAXB = 120;
    localparam int NW   = K * K;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] sa;
        logic [15:0] off;
        logic [7:0]  fn;
        logic [15:0] din;
        bit          mode;
        int          hold;
        int          drop_k;
        int          exp_lat;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    bit   ram_mode = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    logic [15:0]        rd_q[$];
    logic [31:0]        wr_q[$];
    logic [23:0]        fb_q[$];
    logic [NW*DW-1:0]   exp_win = '0;
    vec_t               vecs[8];

    dma_window_engine_if #(.K(K), .DW(DW), .AW(AW)) bus();

    dma_window_engine #(.K(K), .DW(DW), .AW(AW), .MAXB(MAXB)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ram_val(input logic [15:0] a, input bit m);
        return m ? (a ^ 16'h5A5A) : a;
    endfunction

    function automatic logic [15:0] model_addr(input logic [1:0] op, input logic [15:0] sa,
                                               input logic [15:0] off, input logic [7:0] fn,
                                               input int k);
        logic [15:0] r;
        case (op)
            2'd0:    r = sa + 16'(k / K) * off + 16'(k % K);
            2'd2:    r = sa + 16'(fn) * 16'(NW) + 16'(k);
            default: r = sa + 16'(k);
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_window(input string name);
        bit found;
        checks++;
        if (bus.window_out !== exp_win) begin
            failures++;
            found = 1'b0;
            for (int i = 0; i < NW; i++) begin
                if (!found && (bus.window_out[i*DW +: DW] !== exp_win[i*DW +: DW])) begin
                    found = 1'b1;
                    $display("FAIL %s element=%0d actual=%0h required=%0h", name, i,
                             bus.window_out[i*DW +: DW], exp_win[i*DW +: DW]);
                end
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctrl"}, 64'({bus.finish, bus.mem_en, bus.mem_write, bus.fb_write, bus.fb_bias_sel}), 64'd0);
        chk({tag, "_data"}, 64'({bus.mem_addr, bus.mem_wdata, bus.fb_data}), 64'd0);
        chk({tag, "_index"}, 64'(bus.fb_index), 64'd0);
        chk_window({tag, "_window"});
    endtask

    // RAM model with one-cycle read latency.
    always @(posedge clk) begin
        if (bus.mem_en && !bus.mem_write) begin
            bus.mem_rdata <= ram_val(bus.mem_addr, ram_mode);
        end
    end

    // Scoreboard: every RAM access and filter-buffer strobe must match the next expected entry.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_en && !bus.mem_write) begin
                if (rd_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_read actual=%0h required=none", bus.mem_addr);
                end else begin
                    chk("rd_addr", 64'(bus.mem_addr), 64'(rd_q.pop_front()));
                end
            end
            if (bus.mem_en && bus.mem_write) begin
                if (wr_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_write actual=%0h required=none", {bus.mem_addr, bus.mem_wdata});
                end else begin
                    chk("wr_addr_data", 64'({bus.mem_addr, bus.mem_wdata}), 64'(wr_q.pop_front()));
                end
            end
            if (bus.fb_write) begin
                if (fb_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_fb_write actual=%0h required=none",
                             {bus.fb_bias_sel, bus.fb_index, bus.fb_data});
                end else begin
                    chk("fb_sel_idx_data", 64'({bus.fb_bias_sel, bus.fb_index, bus.fb_data}), 64'(fb_q.pop_front()));
                end
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int          n;
        int          cnt;
        logic [15:0] a;
        ram_mode = v.mode;
        if (v.op == 2'd1)      n = 0;
        else if (v.op == 2'd3) n = (int'(v.fn) > MAXB) ? MAXB : int'(v.fn);
        else                   n = NW;
        for (int k = 0; k < n; k++) begin
            a = model_addr(v.op, v.sa, v.off, v.fn, k);
            rd_q.push_back(a);
            if (v.op == 2'd0) exp_win[k*DW +: DW] = ram_val(a, v.mode);
            else              fb_q.push_back({(v.op == 2'd3), 7'(k), ram_val(a, v.mode)});
        end
        if (v.op == 2'd1) wr_q.push_back({v.sa, v.din});

        bus.start = 1'b1; bus.op = v.op; bus.start_address = v.sa;
        bus.offset = v.off; bus.filter_number = v.fn; bus.cnn_in_data = v.din;
        @(posedge clk); #1;
        // Request is latched; these changes must have no effect.
        bus.op = 2'($urandom); bus.start_address = 16'($urandom); bus.offset = 16'($urandom);
        bus.filter_number = 8'($urandom); bus.cnn_in_data = 16'($urandom);
        cnt = 0;
        while (!bus.finish && cnt < 300) begin
            @(posedge clk); #1;
            cnt++;
            if (cnt == v.drop_k) bus.start = 1'b0;
        end
        chk("latency", 64'(cnt), 64'(v.exp_lat));
        if (v.drop_k >= 0) begin
            @(posedge clk); #1;
            chk("finish_single_pulse", 64'(bus.finish), 64'd0);
        end else begin
            for (int h = 1; h < v.hold; h++) begin
                @(posedge clk); #1;
                chk("finish_held", 64'(bus.finish), 64'd1);
            end
            bus.start = 1'b0;
            @(posedge clk); #1;
            chk("finish_drop", 64'(bus.finish), 64'd0);
        end
        chk("reads_left", 64'(rd_q.size()), 64'd0);
        chk("writes_left", 64'(wr_q.size()), 64'd0);
        chk("fb_left", 64'(fb_q.size()), 64'd0);
        chk_window("window");
        rd_q.delete(); wr_q.delete(); fb_q.delete();
    endtask

    task automatic reset_mid_transfer();
        vec_t v;
        ram_mode = 1'b0;
        for (int k = 0; k < NW; k++) rd_q.push_back(model_addr(2'd0, 16'd300, 16'd10, 8'd0, k));
        bus.start = 1'b1; bus.op = 2'd0; bus.start_address = 16'd300;
        bus.offset = 16'd10; bus.filter_number = 8'd0; bus.cnn_in_data = 16'd0;
        @(posedge clk); #1;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_busy_addr", 64'(bus.mem_addr), 64'(model_addr(2'd0, 16'd300, 16'd10, 8'd0, 10)));
        rst_n = 1'b0;
        #1;
        exp_win = '0;
        chk_all_zero("async_rst");
        rd_q.delete();
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold_en", 64'(bus.mem_en), 64'd0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst_quiet", 64'({bus.finish, bus.mem_en}), 64'd0);
        v = '{2'd3, 16'd7, 16'd0, 8'd2, 16'd0, 1'b1, 1, -1, 3};
        run_vec(v);
    endtask

    initial begin
        bus.start = 1'b0; bus.op = 2'd0; bus.start_address = 16'd0;
        bus.offset = 16'd0; bus.filter_number = 8'd0; bus.cnn_in_data = 16'd0;

        //          op     sa          off      fn      din         mode hold drop lat
        vecs[0] = '{2'd0, 16'd100,    16'd32, 8'd0,   16'd0,      1'b0, 1, -1, 26};
        vecs[1] = '{2'd1, 16'hFFFF,   16'd0,  8'd0,   16'h1234,   1'b0, 5, -1, 1};
        vecs[2] = '{2'd2, 16'd0,      16'd0,  8'd3,   16'd0,      1'b1, 2, -1, 26};
        vecs[3] = '{2'd3, 16'd50550,  16'd0,  8'd6,   16'd0,      1'b0, 1, -1, 7};
        vecs[4] = '{2'd3, 16'd1234,   16'd0,  8'd0,   16'd0,      1'b0, 1, -1, 1};
        vecs[5] = '{2'd0, 16'hFFF0,   16'd8,  8'd0,   16'd0,      1'b1, 1,  3, 26};
        vecs[6] = '{2'd3, 16'hFFC0,   16'd0,  8'd200, 16'd0,      1'b1, 1, -1, 121};
        vecs[7] = '{2'd2, 16'hF000,   16'd0,  8'd255, 16'd0,      1'b0, 1, -1, 26};

        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
            if (i == 0) chk("window_r2_c3", 64'(bus.window_out[13*DW +: DW]), 64'd167);
        end

        reset_mid_transfer();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
